train_dispatch_scheduler: RTL and testbench
===========================================

Name: train_dispatch_scheduler

Overview:
- Sequences train dispatch from a shared depot to N dropoff stations. Each station's dropoff logic publishes its train limit L.
- Picks the next eligible station round-robin, grants one depot train at a time via req/gnt/ack, and tracks trains en route per station.
- Arrivals decrement the en-route count. Sits between the per-station dropoff logic outputs and the depot train-stop circuitry.

Parameters:
- N, 4, number of dropoff stations (2..16).
- INT, 31, MSB index of signal words (signal width INT+1).
- IDW, 2, station index width; must equal clog2(N).
- CW, 4, per-station en-route counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- l_flat  in  N*(INT+1)  per-station train limit L, unsigned; station i at bits [i*(INT+1) +: INT+1].
- req  in  1  depot has a train ready; level, held until ack or withdrawn.
- gnt  out  1  dispatch grant valid.
- gnt_id  out  IDW  destination station for the current grant.
- ack  in  1  depot confirms the granted train departed; only meaningful while gnt=1.
- arrive  in  1  one-cycle pulse: a train reached a station.
- arrive_id  in  IDW  station index for arrive.
- enroute_flat  out  N*CW  per-station en-route counts; station i at [i*CW +: CW].
- err  out  1  sticky: arrive at a station with zero en-route, or counter saturation.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, gnt=0, gnt_id=0, rr_ptr=0, all en-route counters=0, err=0. Reset mid-grant drops gnt on the next edge with no count change.
- Eligibility: station i is eligible when zero-extended enroute[i] < L[i]. L=0 means never eligible.
- FSM, states IDLE, SCAN, GRANT:
  - IDLE: if req, go to SCAN next cycle.
  - SCAN: if req=0, go to IDLE. Otherwise search stations rr_ptr, rr_ptr+1, ... mod N for the first eligible one. If found, register gnt_id=i, gnt=1, go to GRANT. If none is eligible, stay in SCAN and re-evaluate every cycle.
  - GRANT: gnt held high and gnt_id held stable.
    - ack=1: en-route count for gnt_id increments, rr_ptr=(gnt_id+1) mod N, gnt=0 next cycle, go to IDLE.
    - req=0 without ack: withdraw; gnt=0 next cycle, IDLE, no count change, rr_ptr unchanged.
    - ack and req=0 in the same cycle: treated as ack.
- Latency: req rising in IDLE gives gnt=1 two cycles later at the earliest (IDLE->SCAN->GRANT). After ack, the next grant comes at the earliest 3 cycles after the ack cycle.
- A grant is never retracted because L drops. Eligibility is checked only in SCAN.
- Arrivals: arrive decrements enroute[arrive_id] if nonzero. If it is zero, the count stays 0 and err=1.
- Simultaneous ack and arrive for the same station: net count unchanged. Different stations: both apply.
- Saturation: an increment at 2^CW-1 holds the count and sets err=1.
- arrive_id >= N: ignored, err=1.
- ack while gnt=0: ignored.
- err clears only on reset.
- enroute_flat is registered; updates are visible the cycle after the causing edge.
- No arithmetic wraps. The comparison is unsigned, CW bits zero-extended to INT+1.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req=1 -> gnt=0, all enroute=0, err=0. Release -> gnt=1 two cycles later, gnt_id=0 (all L=3).
- Round-robin: N=4, all L=1, req held, ack the cycle after each gnt -> gnt_id sequence 0,1,2,3. Then SCAN stalls with gnt=0 and enroute=1,1,1,1. arrive_id=2 -> next gnt_id=2.
- Ineligible skip: L={0,2,0,5}, rr_ptr=0 -> grants go to 1,3,1,3,3,3. Station 1 stops receiving grants at enroute=2.
- Withdraw: req drops during GRANT -> gnt=0 next cycle, enroute unchanged, rr_ptr unchanged, so the next grant goes to the same station.
- Simultaneous ack and arrive on station 1 with enroute[1]=2 -> enroute[1] stays 2. Then arrive on station 0 with enroute[0]=0 -> enroute[0] stays 0, err=1 and stays 1.
- Saturation: CW=4, L[0]=100, 16 acks to station 0 -> enroute[0]=15, err=1.

Source files
------------

// File: rtl/train_dispatch_scheduler_if.sv
// Depot dispatch handshake between the depot stop
// circuitry (master) and the dispatch scheduler (slave).
interface train_dispatch_scheduler_if #(
  parameter int IDW = 2
);
  logic           req;
  logic           ack;
  logic           gnt;
  logic [IDW-1:0] gnt_id;

  modport master (
    output req,
    output ack,
    input  gnt,
    input  gnt_id
  );

  modport slave (
    input  req,
    input  ack,
    output gnt,
    output gnt_id
  );
endinterface

// File: rtl/train_dispatch_scheduler.sv
// Round-robin train dispatch from one depot to N
// dropoff stations, with per-station en-route tracking.
module train_dispatch_scheduler #(
  parameter int N   = 4,
  parameter int INT = 31,
  parameter int IDW = 2,
  parameter int CW  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*(INT+1)-1:0] l_flat,
  train_dispatch_scheduler_if.slave bus,
  input  logic                 arrive,
  input  logic [IDW-1:0]       arrive_id,
  output logic [N*CW-1:0]      enroute_flat,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    GRANT
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] gnt_id_q;
  logic [IDW-1:0] gnt_id_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] rr_nxt;
  logic [IDW-1:0] probe;
  logic [IDW-1:0] pick;
  logic           found;
  logic           ack_fire;
  logic           err_set;
  logic [N-1:0]   elig;
  logic [N-1:0]   inc_v;
  logic [N-1:0]   dec_v;
  logic [CW-1:0]  cnt     [N];
  logic [CW-1:0]  cnt_nxt [N];

  assign ack_fire   = (state == GRANT) && bus.ack;
  assign bus.gnt    = (state == GRANT);
  assign bus.gnt_id = gnt_id_q;

  for (genvar i = 0; i < N; i++) begin : g_st
    assign elig[i] = (INT+1)'(cnt[i])
                   < l_flat[i*(INT+1) +: INT+1];
    assign inc_v[i] = ack_fire
                    && (gnt_id_q == IDW'(i));
    assign dec_v[i] = arrive
                    && (arrive_id == IDW'(i));
    assign enroute_flat[i*CW +: CW] = cnt[i];
  end

  // first eligible station at or after rr_ptr
  always_comb begin
    found = 1'b0;
    pick  = '0;
    probe = '0;
    for (int k = 0; k < N; k++) begin
      probe = IDW'((int'(rr_ptr) + k) % N);
      if (!found && elig[probe]) begin
        found = 1'b1;
        pick  = probe;
      end
    end
  end

  // dispatch state machine: next state and grant bookkeeping
  always_comb begin
    state_nxt  = state;
    gnt_id_nxt = gnt_id_q;
    rr_nxt     = rr_ptr;
    unique case (state)
      IDLE: begin
        if (bus.req) state_nxt = SCAN;
      end
      SCAN: begin
        if (!bus.req) begin
          state_nxt = IDLE;
        end else if (found) begin
          state_nxt  = GRANT;
          gnt_id_nxt = pick;
        end
      end
      GRANT: begin
        if (bus.ack) begin
          state_nxt = IDLE;
          rr_nxt = (gnt_id_q == IDW'(N-1))
                 ? '0 : gnt_id_q + IDW'(1);
        end else if (!bus.req) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state, grant id and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_id_q <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      gnt_id_q <= gnt_id_nxt;
      rr_ptr   <= rr_nxt;
    end
  end

  // en-route counts: saturate on overflow, floor at zero
  always_comb begin
    err_set = arrive
            && (32'(arrive_id) >= 32'(N));
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i] = cnt[i];
      if (inc_v[i] && !dec_v[i]) begin
        if (&cnt[i]) err_set = 1'b1;
        else cnt_nxt[i] = cnt[i] + CW'(1);
      end else if (dec_v[i] && !inc_v[i]) begin
        if (cnt[i] == '0) err_set = 1'b1;
        else cnt_nxt[i] = cnt[i] - CW'(1);
      end
    end
  end

  // count registers and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '{default: '0};
      err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      err <= err | err_set;
    end
  end

endmodule

// File: tb/tb_train_dispatch_scheduler.sv
// Directed and random stimulus against a cycle-level
// behavioural model of the dispatch rules.
module tb_train_dispatch_scheduler;
  localparam int N    = 4;
  localparam int INT  = 31;
  localparam int IDW  = 2;
  localparam int CW   = 4;
  localparam int W    = INT + 1;
  localparam int MAXC = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] l_flat;
  logic           arrive;
  logic [IDW-1:0] arrive_id;
  logic [N*CW-1:0] enroute_flat;
  logic           err;
  logic [W-1:0]   lim [N];

  train_dispatch_scheduler_if #(.IDW(IDW)) bus ();

  train_dispatch_scheduler #(
    .N(N), .INT(INT), .IDW(IDW), .CW(CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .l_flat       (l_flat),
    .bus          (bus),
    .arrive       (arrive),
    .arrive_id    (arrive_id),
    .enroute_flat (enroute_flat),
    .err          (err)
  );

  always #5 clk = ~clk;

  always_comb begin
    l_flat = '0;
    for (int i = 0; i < N; i++)
      l_flat[i*W +: W] = lim[i];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int enr(int s);
    return int'(enroute_flat[s*CW +: CW]);
  endfunction

  // behavioural model
  bit m_valid = 0;
  bit m_gnt;
  bit m_scan;
  bit m_err;
  int m_gid;
  int m_rr;
  int m_cnt [N];
  int m_old [N];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_gnt = 0; m_scan = 0; m_err = 0;
      m_gid = 0; m_rr = 0;
      for (int s = 0; s < N; s++) m_cnt[s] = 0;
      m_valid = 1;
    end else begin
      for (int s = 0; s < N; s++) m_old[s] = m_cnt[s];
      if (arrive && int'(arrive_id) >= N) m_err = 1;
      for (int s = 0; s < N; s++) begin
        bit up, dn;
        up = m_gnt && bus.ack && (m_gid == s);
        dn = arrive && (int'(arrive_id) == s);
        if (up && !dn) begin
          if (m_cnt[s] == MAXC) m_err = 1;
          else m_cnt[s] = m_cnt[s] + 1;
        end else if (dn && !up) begin
          if (m_cnt[s] == 0) m_err = 1;
          else m_cnt[s] = m_cnt[s] - 1;
        end
      end
      if (m_gnt) begin
        if (bus.ack) begin
          m_gnt = 0;
          m_rr  = (m_gid + 1) % N;
        end else if (!bus.req) begin
          m_gnt = 0;
        end
      end else if (!m_scan) begin
        m_scan = bus.req;
      end else if (!bus.req) begin
        m_scan = 0;
      end else begin
        for (int k = 0; k < N; k++) begin
          int s;
          s = (m_rr + k) % N;
          if (!m_gnt && $unsigned(m_old[s]) < lim[s]) begin
            m_gnt = 1; m_gid = s; m_scan = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("gnt", int'(bus.gnt), int'(m_gnt));
      if (m_gnt) chk("gnt_id", int'(bus.gnt_id), m_gid);
      for (int s = 0; s < N; s++)
        chk($sformatf("enroute%0d", s), enr(s), m_cnt[s]);
      chk("err", int'(err), int'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_l(int a, int b, int c, int d);
    lim[0] = W'(a); lim[1] = W'(b);
    lim[2] = W'(c); lim[3] = W'(d);
  endtask

  task automatic do_reset();
    rst_n = 0; bus.req = 0; bus.ack = 0; arrive = 0;
    step(); step();
    rst_n = 1;
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.gnt) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("gnt_timeout", 0, 1);
  endtask

  task automatic grant_ack(output int id);
    bit ok;
    wait_gnt(ok);
    id = ok ? int'(bus.gnt_id) : -1;
    bus.ack = 1;
    step();
    bus.ack = 0;
  endtask

  int seq [6];
  int id;
  bit ok;

  initial begin
    rst_n = 0; bus.req = 1; bus.ack = 0;
    arrive = 0; arrive_id = '0;
    set_l(3, 3, 3, 3);
    step(); step();
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_enroute", int'(enroute_flat), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1;
    step();
    chk("lat1_gnt", int'(bus.gnt), 0);
    step();
    chk("lat2_gnt", int'(bus.gnt), 1);
    chk("lat2_id", int'(bus.gnt_id), 0);

    // round robin
    do_reset();
    set_l(1, 1, 1, 1);
    bus.req = 1;
    for (int i = 0; i < 4; i++) grant_ack(seq[i]);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_seq%0d", i), seq[i], i);
    repeat (5) step();
    chk("rr_stall_gnt", int'(bus.gnt), 0);
    chk("rr_counts", int'(enroute_flat), 16'h1111);
    arrive = 1; arrive_id = 2;
    step();
    arrive = 0;
    grant_ack(id);
    chk("rr_after_arrive", id, 2);

    // ineligible skip
    do_reset();
    set_l(0, 2, 0, 5);
    bus.req = 1;
    for (int i = 0; i < 6; i++) grant_ack(seq[i]);
    chk("skip0", seq[0], 1); chk("skip1", seq[1], 3);
    chk("skip2", seq[2], 1); chk("skip3", seq[3], 3);
    chk("skip4", seq[4], 3); chk("skip5", seq[5], 3);
    chk("skip_cnt1", enr(1), 2);
    chk("skip_cnt3", enr(3), 4);

    // withdraw
    do_reset();
    set_l(3, 3, 3, 3);
    bus.req = 1;
    grant_ack(id);
    wait_gnt(ok);
    chk("wd_id", int'(bus.gnt_id), 1);
    bus.req = 0;
    step();
    chk("wd_gnt", int'(bus.gnt), 0);
    chk("wd_cnt1", enr(1), 0);
    bus.req = 1;
    wait_gnt(ok);
    chk("wd_regrant", int'(bus.gnt_id), 1);
    bus.ack = 1; step(); bus.ack = 0;

    // simultaneous ack+arrive, then arrive at empty
    do_reset();
    set_l(0, 3, 0, 0);
    bus.req = 1;
    grant_ack(id);
    grant_ack(id);
    wait_gnt(ok);
    bus.ack = 1; arrive = 1; arrive_id = 1;
    step();
    bus.ack = 0; arrive = 0; bus.req = 0;
    chk("sim_cnt1", enr(1), 2);
    chk("sim_err", int'(err), 0);
    arrive = 1; arrive_id = 0;
    step();
    arrive = 0;
    chk("empty_cnt0", enr(0), 0);
    chk("empty_err", int'(err), 1);
    repeat (3) step();
    chk("err_sticky", int'(err), 1);

    // saturation
    do_reset();
    set_l(100, 0, 0, 0);
    bus.req = 1;
    for (int i = 0; i < 16; i++) grant_ack(id);
    chk("sat_cnt0", enr(0), 15);
    chk("sat_err", int'(err), 1);

    // random
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0)
        for (int s = 0; s < N; s++)
          lim[s] = W'($urandom_range(0, 5));
      if ($urandom_range(0, 499) == 0) rst_n = 0;
      else rst_n = 1;
      if (bus.gnt) bus.req = ($urandom_range(0, 19) != 0);
      else bus.req = ($urandom_range(0, 9) < 7);
      bus.ack = bus.gnt ? ($urandom_range(0, 2) == 0)
                        : ($urandom_range(0, 9) == 0);
      arrive    = ($urandom_range(0, 3) == 0);
      arrive_id = IDW'($urandom_range(0, N - 1));
      step();
    end
    rst_n = 1; bus.req = 0; bus.ack = 0; arrive = 0;
    step(); step();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
